// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: one WIDTH-bit register shared by NREQ requesters through a
// round-robin IDLE/ACCESS FSM. Define LOCK_EN to add the lock port and owner locking.
module shared_reg_arbiter #(
  parameter  int WIDTH    = 8,
  parameter  int NREQ     = 4,
  parameter  int MAX_LOCK = 4,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic [IDW-1:0]        owner
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_reg,   state_next;
  logic [IDW-1:0]    ptr_reg,     ptr_next;
  logic [IDW-1:0]    owner_reg,   owner_next;
  logic [NREQ-1:0]   gnt_reg,     gnt_next;
  logic [NREQ-1:0]   ack_reg,     ack_next;
  logic [WIDTH-1:0]  rdata_reg,   rdata_next;
  logic              rvalid_reg,  rvalid_next;
  logic              busy_reg,    busy_next;
  logic [WIDTH-1:0]  storage_reg, storage_next;

  logic [WIDTH-1:0]  lane [NREQ];
  logic [NREQ-1:0]   eligible;
  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic              relock;
  logic              do_grant;
  logic [IDW-1:0]    grant_idx;

  if (NREQ < 2 || MAX_LOCK < 1) begin : g_param_check
    $error("shared_reg_arbiter: NREQ must be >= 2 and MAX_LOCK >= 1");
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // The requester acked on the previous access is masked so it cannot win twice in a row.
  assign eligible = req & ~ack_reg;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_found && eligible[(int'(ptr_reg) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

`ifdef LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK) + 1;
  logic [LCW-1:0] lock_cnt_reg;
  logic           lock_hold_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt_reg  <= '0;
      lock_hold_reg <= 1'b0;
    end else if (state_reg == ACCESS) begin
      if (lock[owner_reg] && (lock_cnt_reg < LCW'(MAX_LOCK - 1))) begin
        lock_hold_reg <= 1'b1;
        lock_cnt_reg  <= lock_cnt_reg + 1'b1;
      end else begin
        lock_hold_reg <= 1'b0;
        lock_cnt_reg  <= '0;
      end
    end else begin
      lock_hold_reg <= 1'b0;
    end
  end

  assign relock = lock_hold_reg && req[owner_reg];
`else
  assign relock = 1'b0;
`endif

  assign do_grant  = relock || pick_found;
  assign grant_idx = relock ? owner_reg : pick_idx;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    gnt_next     = gnt_reg;
    ack_next     = ack_reg;
    rdata_next   = rdata_reg;
    rvalid_next  = rvalid_reg;
    busy_next    = busy_reg;
    storage_next = storage_reg;
    unique case (state_reg)
      IDLE: begin
        ack_next    = '0;
        rvalid_next = 1'b0;
        if (do_grant) begin
          owner_next = grant_idx;
          gnt_next   = NREQ'(1) << grant_idx;
          busy_next  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Commits regardless of req[owner] during this cycle.
        if (wr[owner_reg]) begin
          storage_next = lane[owner_reg];
        end else begin
          rdata_next  = storage_reg;
          rvalid_next = 1'b1;
        end
        ack_next   = NREQ'(1) << owner_reg;
        gnt_next   = '0;
        busy_next  = 1'b0;
        ptr_next   = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= IDW'(NREQ - 1);
      owner_reg   <= '0;
      gnt_reg     <= '0;
      ack_reg     <= '0;
      rdata_reg   <= '0;
      rvalid_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      storage_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      owner_reg   <= owner_next;
      gnt_reg     <= gnt_next;
      ack_reg     <= ack_next;
      rdata_reg   <= rdata_next;
      rvalid_reg  <= rvalid_next;
      busy_reg    <= busy_next;
      storage_reg <= storage_next;
    end
  end

  assign gnt    = gnt_reg;
  assign ack    = ack_reg;
  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign busy   = busy_reg;
  assign owner  = owner_reg;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (WIDTH=8, NREQ=4, MAX_LOCK=4); cycle vector table
// plus grant-order sequences. Lock behaviour is checked when LOCK_EN is defined.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  wr = '0;
  logic [31:0] wdata = '0;
`ifdef LOCK_EN
  logic [3:0]  lock = '0;
`endif
  logic [3:0]  gnt, ack;
  logic [7:0]  rdata;
  logic        rvalid, busy;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata),
`ifdef LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .rdata(rdata), .rvalid(rvalid), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; wr = '0; wdata = '0;
`ifdef LOCK_EN
    lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_grants(input string nm, input int exp_ord[5]);
    int got;
    int cyc;
    logic [3:0] one;
    logic [3:0] exp_g;
    one = 4'b0001;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (gnt != '0) begin
        exp_g = one << exp_ord[got];
        n_cmp++;
        if (gnt !== exp_g) begin
          n_err++;
          $display("FAIL %s grant %0d: got gnt=%b, expected %b", nm, got, gnt, exp_g);
        end else begin
          $display("%s grant %0d: gnt=%b owner=%0d", nm, got, gnt, owner);
        end
        got++;
      end
    end
    if (got < 5) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got %0d grants, expected 5", nm, got);
    end
  endtask

  initial begin
    int rr_exp[5];
    int lk_exp[5];

    //          rst req      wr       wdata          gnt      ack      rv rdata  busy own
    tv[0]  = '{1'b1, 4'b0001, 4'b0001, 32'h112233A5, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0};
    tv[1]  = '{1'b1, 4'b0001, 4'b0001, 32'h112233A5, 4'b0000, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[2]  = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[3]  = '{1'b1, 4'b0010, 4'b0000, 32'h00000000, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1};
    tv[4]  = '{1'b1, 4'b0010, 4'b0000, 32'h00000000, 4'b0000, 4'b0010, 1'b1, 8'hA5, 1'b0, 2'd1};
    tv[5]  = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd1};
    tv[6]  = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[7]  = '{1'b1, 4'b1100, 4'b0100, 32'h553C7766, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2};
    tv[8]  = '{1'b1, 4'b1100, 4'b0100, 32'h553C7766, 4'b0000, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd2};
    tv[9]  = '{1'b1, 4'b1000, 4'b0000, 32'h553C7766, 4'b1000, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd3};
    tv[10] = '{1'b1, 4'b1000, 4'b0000, 32'h553C7766, 4'b0000, 4'b1000, 1'b1, 8'h3C, 1'b0, 2'd3};
    tv[11] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h3C, 1'b0, 2'd3};
    tv[12] = '{1'b1, 4'b0001, 4'b0001, 32'hEEDDCCFF, 4'b0001, 4'b0000, 1'b0, 8'h3C, 1'b1, 2'd0};
    tv[13] = '{1'b0, 4'b0001, 4'b0001, 32'hEEDDCCFF, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[14] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tv[15] = '{1'b1, 4'b0001, 4'b0000, 32'h00000000, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0};
    tv[16] = '{1'b1, 4'b0001, 4'b0000, 32'h00000000, 4'b0000, 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0};
    tv[17] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

    rr_exp = '{0, 1, 2, 3, 0};
`ifdef LOCK_EN
    lk_exp = '{0, 0, 0, 0, 1};
`else
    lk_exp = '{0, 1, 0, 1, 0};
`endif

    // Reset state
    do_reset();
    chk("reset_gnt", -1, 32'(gnt), 32'h0);
    chk("reset_ack", -1, 32'(ack), 32'h0);
    chk("reset_rvalid", -1, 32'(rvalid), 32'h0);
    chk("reset_rdata", -1, 32'(rdata), 32'h0);
    chk("reset_busy", -1, 32'(busy), 32'h0);
    chk("reset_owner", -1, 32'(owner), 32'h0);
    $display("reset: gnt=%b ack=%b rvalid=%b rdata=%h busy=%b", gnt, ack, rvalid, rdata, busy);

    // Cycle table: write/read, contention from reset, reset mid-write
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; wr = tv[i].wr; wdata = tv[i].wdata;
      @(posedge clk);
      #1;
      chk("gnt", i, 32'(gnt), 32'(tv[i].gnt));
      chk("ack", i, 32'(ack), 32'(tv[i].ack));
      chk("rvalid", i, 32'(rvalid), 32'(tv[i].rvalid));
      chk("rdata", i, 32'(rdata), 32'(tv[i].rdata));
      chk("busy", i, 32'(busy), 32'(tv[i].busy));
      chk("owner", i, 32'(owner), 32'(tv[i].owner));
      $display("step %0d: rst=%b req=%b wr=%b -> gnt=%b ack=%b rvalid=%b rdata=%h busy=%b owner=%0d",
               i, rst, req, wr, gnt, ack, rvalid, rdata, busy, owner);
    end

    // Round-robin: all four reads held
    do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; wr = 4'b0000;
    check_grants("rr", rr_exp);

    // Two requesters held, requester 0 asking for lock
    do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0011; wr = 4'b0000;
`ifdef LOCK_EN
    lock = 4'b0001;
`endif
    check_grants("lock", lk_exp);

    @(negedge clk);
    req = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
